// File: rtl/pipelined_carry_increment_adder.sv
// ---------------------------------------------------------------------------
// pipelined_carry_increment_adder
//
// Pipelined carry-increment adder/subtractor with valid/ready handshakes on
// both sides.  Operands are cut into BLK-bit blocks.  Each pipeline stage
// resolves K = N/(BLK*STAGES) consecutive blocks.  The first block of a stage
// ripple-adds with the carry registered by the previous stage.  Every later
// block precomputes its sum for carry-in 0 and then increments on the carry
// arriving from below.  Only one carry bit crosses each stage boundary, so no
// combinational carry path is longer than K blocks.
//
// The pipeline advances as a whole.  en = ~out_valid | out_ready.  Bubbles
// travel with the beats and are not squeezed out.
//
// Parameter constraints: N % BLK == 0, (N/BLK) % STAGES == 0, STAGES >= 1.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat is accepted this cycle (combinational, equals en)
//   sub        0: in1 + in2, 1: in1 - in2 (sampled with the operands)
//   in1, in2   operands A and B
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum        result
//   cout       carry out of bit N-1 (for sub, 1 means no borrow)
//   of         signed overflow
//   zero       sum == 0
// ---------------------------------------------------------------------------
module pipelined_carry_increment_adder #(
  parameter int N      = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         of,
  output logic         zero
);

  localparam int NB = N / BLK;
  localparam int K  = NB / STAGES;
  localparam int L  = STAGES - 1;
  localparam int PR = (STAGES > 1) ? STAGES - 1 : 1;

  // Plain ripple block: {carry_out, sum}.
  function automatic logic [BLK:0] ripple_blk(input logic [BLK-1:0] a,
                                              input logic [BLK-1:0] b,
                                              input logic           cin);
    return {1'b0, a} + {1'b0, b} + (BLK+1)'(cin);
  endfunction

  // Carry-increment block: sum for carry-in 0 plus generate/propagate-all,
  // then increment on the real carry.  cout = g | (p & cin).
  function automatic logic [BLK:0] incr_blk(input logic [BLK-1:0] a,
                                            input logic [BLK-1:0] b,
                                            input logic           cin);
    logic [BLK:0]   s0;
    logic           p;
    logic [BLK-1:0] s;
    s0 = {1'b0, a} + {1'b0, b};
    p  = &(a ^ b);
    s  = s0[BLK-1:0] + BLK'(cin);
    return {s0[BLK] | (p & cin), s};
  endfunction

  // Inter-stage registers: register k holds the result of stage k.
  logic [N-1:0]  pa_q [PR];
  logic [N-1:0]  pb_q [PR];
  logic [N-1:0]  ps_q [PR];
  logic [PR-1:0] pc_q;
  logic [PR-1:0] pv_q;

  // Output stage registers.
  logic         out_valid_q;
  logic [N-1:0] sum_q;
  logic         cout_q;
  logic         of_q;
  logic         zero_q;

  // Per-stage combinational inputs and resolved results.
  logic [N-1:0]      st_a  [STAGES];
  logic [N-1:0]      st_b  [STAGES];
  logic [N-1:0]      st_si [STAGES];
  logic [N-1:0]      st_so [STAGES];
  logic [STAGES-1:0] st_ci;
  logic [STAGES-1:0] st_co;
  logic [STAGES-1:0] st_v;

  logic         en;
  logic [N-1:0] sum_d;
  logic         cout_d;
  logic         of_d;
  logic         zero_d;

  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  always_comb begin
    logic [BLK:0] r;
    logic         c;
    r = '0;
    c = 1'b0;
    for (int j = 0; j < STAGES; j++) begin
      if (j == 0) begin
        // Subtraction folds into addition: B' = ~B, carry-in = 1.
        st_a[j]  = in1;
        st_b[j]  = in2 ^ {N{sub}};
        st_si[j] = '0;
        st_ci[j] = sub;
        st_v[j]  = in_valid;
      end else begin
        st_a[j]  = pa_q[(j > 0) ? j - 1 : 0];
        st_b[j]  = pb_q[(j > 0) ? j - 1 : 0];
        st_si[j] = ps_q[(j > 0) ? j - 1 : 0];
        st_ci[j] = pc_q[(j > 0) ? j - 1 : 0];
        st_v[j]  = pv_q[(j > 0) ? j - 1 : 0];
      end

      st_so[j] = st_si[j];
      c        = st_ci[j];
      for (int i = 0; i < K; i++) begin
        if (i == 0)
          r = ripple_blk(st_a[j][(j*K+i)*BLK +: BLK], st_b[j][(j*K+i)*BLK +: BLK], c);
        else
          r = incr_blk(st_a[j][(j*K+i)*BLK +: BLK], st_b[j][(j*K+i)*BLK +: BLK], c);
        st_so[j][(j*K+i)*BLK +: BLK] = r[BLK-1:0];
        c = r[BLK];
      end
      st_co[j] = c;
    end
  end

  // Overflow: operands (after inversion) share a sign that the result lacks,
  // which is equivalent to carry-in XOR carry-out of the top bit.
  assign sum_d  = st_so[L];
  assign cout_d = st_co[L];
  assign of_d   = (st_a[L][N-1] ~^ st_b[L][N-1]) & (st_so[L][N-1] ^ st_a[L][N-1]);
  assign zero_d = ~|st_so[L];

  // ---- stage boundaries 1..STAGES-1: operand/partial-sum registers ----
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        pa_q[k] <= st_a[k];
        pb_q[k] <= st_b[k];
        ps_q[k] <= st_so[k];
        pc_q[k] <= st_co[k];
      end
    end
  end

  // ---- valid chain and output stage (reset clears results too) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q        <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      of_q        <= 1'b0;
      zero_q      <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        pv_q[k] <= st_v[k];
      end
      out_valid_q <= st_v[L];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      of_q        <= of_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign of        = of_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_carry_increment_adder.sv
module tb_pipelined_carry_increment_adder;

  localparam int N = 32;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic         sub       = 1'b0;
  logic [N-1:0] in1       = '0;
  logic [N-1:0] in2       = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] sum;
  logic         cout;
  logic         of;
  logic         zero;

  int checks = 0;
  int errors = 0;

  pipelined_carry_increment_adder #(.N(32), .BLK(4), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .of        (of),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hand-computed vectors: sub, a, b, sum, cout, of, zero
  localparam logic        V_S [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [31:0] V_A [6] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005,
                                      32'h80000000, 32'h0000FFFF, 32'h00000007};
  localparam logic [31:0] V_B [6] = '{32'h00000001, 32'h00000001, 32'h00000007,
                                      32'h00000001, 32'h00000001, 32'h00000007};
  localparam logic [31:0] V_E [6] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFE,
                                      32'h7FFFFFFF, 32'h00010000, 32'h00000000};
  localparam logic        V_C [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic        V_O [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic        V_Z [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if ({sum, cout, of, zero} !== 35'd0) begin
      errors++; $display("FAIL reset_outputs: got sum=%h c=%b o=%b z=%b want all 0", sum, cout, of, zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_arith();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; sub = V_S[i]; in1 = V_A[i]; in2 = V_B[i];
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL arith%0d_latency: out_valid=%b one cycle after accept, want 0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL arith%0d_valid: got %b want 1", i, out_valid);
      end
      checks++;
      if (sum !== V_E[i]) begin
        errors++; $display("FAIL arith%0d_sum: got %h want %h", i, sum, V_E[i]);
      end
      checks++;
      if ({cout, of, zero} !== {V_C[i], V_O[i], V_Z[i]}) begin
        errors++; $display("FAIL arith%0d_flags: got c=%b o=%b z=%b want c=%b o=%b z=%b",
                           i, cout, of, zero, V_C[i], V_O[i], V_Z[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sa [9];
    logic [31:0] sb [9];
    logic [32:0] r;
    logic        eo;
    int first = -1;
    int last  = -1;
    int got   = 0;
    for (int i = 0; i < 8; i++) begin
      sa[i] = i;
      sb[i] = 32'h11111111 * i;
    end
    sa[8] = 32'h0000FFFF;
    sb[8] = 32'h00000001;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        if (got < 9) begin
          r  = {1'b0, sa[got]} + {1'b0, sb[got]};
          eo = (sa[got][31] == sb[got][31]) && (r[31] != sa[got][31]);
          checks++;
          if (sum !== r[31:0] || {cout, of, zero} !== {r[32], eo, (r[31:0] == 32'd0)}) begin
            errors++; $display("FAIL stream%0d: got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                               got, sum, cout, of, zero, r[31:0], r[32], eo, (r[31:0] == 32'd0));
          end
        end else begin
          checks++; errors++;
          $display("FAIL stream_extra: unexpected beat sum=%h", sum);
        end
        got++;
      end
      if (cyc < 9) begin
        in_valid = 1'b1; sub = 1'b0; in1 = sa[cyc]; in2 = sb[cyc];
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (first !== 2) begin
      errors++; $display("FAIL stream_first: got cycle %0d want 2", first);
    end
    checks++;
    if (last !== 10 || got !== 9) begin
      errors++; $display("FAIL stream_count: got last=%0d beats=%0d want last=10 beats=9", last, got);
    end
  endtask

  task automatic test_stall();
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] r;
    logic        eo;
    logic [34:0] held;
    int sent = 0;
    int got  = 0;
    int stall_n = 0;
    held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (out_valid === 1'b1 && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready: got %b want 0 at cycle %0d", in_ready, cyc);
        end
        if (stall_n == 0) begin
          held = {sum, cout, of, zero};
        end else begin
          checks++;
          if ({sum, cout, of, zero} !== held) begin
            errors++; $display("FAIL stall_hold: got %h want %h at cycle %0d", {sum, cout, of, zero}, held, cyc);
          end
        end
        stall_n++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL stall_extra: unexpected beat sum=%h", sum);
        end else begin
          a  = qa.pop_front();
          b  = qb.pop_front();
          r  = {1'b0, a} + {1'b0, b};
          eo = (a[31] == b[31]) && (r[31] != a[31]);
          if (sum !== r[31:0] || {cout, of, zero} !== {r[32], eo, (r[31:0] == 32'd0)}) begin
            errors++; $display("FAIL stall_beat%0d: got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                               got, sum, cout, of, zero, r[31:0], r[32], eo, (r[31:0] == 32'd0));
          end
          got++;
        end
      end
      if (sent < 6) begin
        in_valid = 1'b1; sub = 1'b0;
        in1 = 32'h7FFFFFFC + sent; in2 = 32'h00000002;
        #1;
        if (in_ready === 1'b1) begin
          qa.push_back(in1);
          qb.push_back(in2);
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    checks++;
    if (stall_n !== 3) begin
      errors++; $display("FAIL stall_cycles: got %0d want 3", stall_n);
    end
    checks++;
    if (got !== 6) begin
      errors++; $display("FAIL stall_drain: got %0d beats want 6", got);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; sub = 1'b0; in1 = 32'h0000AAAA; in2 = 32'h00000001;
    @(negedge clk);
    in1 = 32'h12345678; in2 = 32'h11111111;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre_valid: got %b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 32'd0) begin
      errors++; $display("FAIL areset_immediate: got valid=%b sum=%h want valid=0 sum=0", out_valid, sum);
    end
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL areset_stale%0d: got valid=%b sum=%h want valid=0", cyc, out_valid, sum);
      end
    end
    in_valid = 1'b1; sub = 1'b0; in1 = 32'd3; in2 = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sum !== 32'd7 || {cout, of, zero} !== 3'b000) begin
      errors++; $display("FAIL areset_fresh: got valid=%b sum=%h c=%b o=%b z=%b want valid=1 sum=7 flags 000",
                         out_valid, sum, cout, of, zero);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
